// File: rtl/seg_frame_builder.sv
// Builds one active-low 7-segment frame per trigger, one digit per cycle, and hands
// it to the serial shifter with a 2-cycle sync pulse, never disturbing a running shift.
`timescale 1ns/1ps
module seg_frame_builder #(
    parameter int DIGITS         = 8,
    parameter int REFRESH_CYCLES = 0,
    parameter int START_TIMEOUT  = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [4*DIGITS-1:0]   hex_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_in,
    input  logic                  update,
    input  logic                  sen,
    output logic [8*DIGITS-1:0]   frame_out,
    output logic                  sync,
    output logic                  busy
);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
    localparam logic [31:0] TIMEOUT_LAST = (START_TIMEOUT > 0) ? 32'(START_TIMEOUT - 1) : 32'd0;

    typedef enum logic [2:0] {IDLE, BUILD, SYNC, WAIT_START, WAIT_DONE} state_t;

    state_t              state;
    logic [4*DIGITS-1:0] hex_shadow;
    logic [DIGITS-1:0]   dp_shadow;
    logic [DIGITS-1:0]   blank_shadow;
    logic [IDX_W-1:0]    idx;
    logic                pending;
    logic                sync_cnt;
    logic [31:0]         timer;
    logic                refresh_hit;
    logic                trigger;
    logic [7:0]          seg_raw;
    logic [7:0]          cur_byte;

    function automatic logic [7:0] seg_decode(input logic [3:0] value);
        logic [7:0] seg;
        case (value)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            4'hF: seg = 8'h8E;
        endcase
        return seg;
    endfunction

    // Free-running refresh tick; independent of update so the period stays fixed.
    generate
        if (REFRESH_CYCLES > 0) begin : g_refresh
            logic [31:0] refresh_cnt;
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    refresh_cnt <= 32'd0;
                end else if (refresh_cnt == 32'(REFRESH_CYCLES - 1)) begin
                    refresh_cnt <= 32'd0;
                end else begin
                    refresh_cnt <= refresh_cnt + 32'd1;
                end
            end
            assign refresh_hit = (refresh_cnt == 32'(REFRESH_CYCLES - 1));
        end else begin : g_no_refresh
            assign refresh_hit = 1'b0;
        end
    endgenerate

    assign trigger = update | refresh_hit;

    always_comb begin
        seg_raw  = seg_decode(hex_shadow[idx*4 +: 4]);
        cur_byte = 8'hFF;
        if (!blank_shadow[idx]) begin
            cur_byte = {~dp_shadow[idx], seg_raw[6:0]};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            frame_out    <= '1;
            sync         <= 1'b0;
            busy         <= 1'b0;
            pending      <= 1'b0;
            hex_shadow   <= '0;
            dp_shadow    <= '0;
            blank_shadow <= '0;
            idx          <= '0;
            sync_cnt     <= 1'b0;
            timer        <= 32'd0;
        end else begin
            if (trigger && state != IDLE) begin
                pending <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (trigger || pending) begin
                        hex_shadow   <= hex_in;
                        dp_shadow    <= dp_in;
                        blank_shadow <= blank_in;
                        pending      <= 1'b0;
                        idx          <= '0;
                        busy         <= 1'b1;
                        state        <= BUILD;
                    end
                end
                BUILD: begin
                    frame_out[idx*8 +: 8] <= cur_byte;
                    if (idx != LAST_IDX) begin
                        idx <= idx + 1'b1;
                    end else if (sen) begin
                        // Hold on the last byte until the shifter is idle so sync never overlaps a shift.
                        sync     <= 1'b1;
                        sync_cnt <= 1'b0;
                        state    <= SYNC;
                    end
                end
                SYNC: begin
                    if (sync_cnt) begin
                        sync  <= 1'b0;
                        timer <= 32'd0;
                        state <= WAIT_START;
                    end else begin
                        sync_cnt <= 1'b1;
                    end
                end
                WAIT_START: begin
                    if (!sen) begin
                        state <= WAIT_DONE;
                    end else if (timer >= TIMEOUT_LAST) begin
                        pending <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                WAIT_DONE: begin
                    if (sen) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    sync  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
